// File: rtl/io_control.sv
// LC-3 memory-mapped device registers (KBSR/KBDR/DSR/DDR/MCR) with a one-byte
// keyboard buffer, a one-byte display buffer and a two-state access handshake.
module io_control #(
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06,
  parameter logic [15:0] MCR_ADDR  = 16'hFFFE
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic [15:0] i_MAR,
  input  logic [15:0] i_MDR,
  input  logic        i_MIO_EN,
  input  logic        i_RW,
  output logic        o_IO_Sel,
  output logic [15:0] o_Data,
  output logic        o_Ready_Bit,
  input  logic [7:0]  i_KB_Data,
  input  logic        i_KB_Valid,
  output logic        o_KB_Ready,
  output logic [7:0]  o_DSP_Data,
  output logic        o_DSP_Valid,
  input  logic        i_DSP_Ready,
  output logic        o_KB_Int,
  output logic        o_Run
);

  typedef enum logic {IDLE, DONE} state_t;
  state_t state;

  logic       kb_full, kb_ie, dsp_empty, dsp_ie, run;
  logic [7:0] kb_byte;

  logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_mcr;
  logic start, rd, wr, kb_hs, dsp_hs;
  logic [15:0] rdata;
  logic unused_mdr;

  assign sel_kbsr = (i_MAR == KBSR_ADDR);
  assign sel_kbdr = (i_MAR == KBDR_ADDR);
  assign sel_dsr  = (i_MAR == DSR_ADDR);
  assign sel_ddr  = (i_MAR == DDR_ADDR);
  assign sel_mcr  = (i_MAR == MCR_ADDR);
  assign o_IO_Sel = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr | sel_mcr;

  // Side effects fire only on the IDLE->DONE edge, so a long DONE cannot repeat them.
  assign start  = (state == IDLE) & i_MIO_EN & o_IO_Sel;
  assign rd     = start & ~i_RW;
  assign wr     = start & i_RW;
  assign kb_hs  = i_KB_Valid & ~kb_full;
  assign dsp_hs = o_DSP_Valid & i_DSP_Ready;

  assign o_KB_Ready = ~kb_full;
  assign o_KB_Int   = kb_full & kb_ie;
  assign o_Run      = run;
  assign unused_mdr = ^i_MDR[13:8];

  always_comb begin
    rdata = 16'h0000;
    if (sel_kbsr)      rdata = {kb_full, kb_ie, 14'b0};
    else if (sel_kbdr) rdata = {8'h00, kb_byte};
    else if (sel_dsr)  rdata = {dsp_empty, dsp_ie, 14'b0};
    else if (sel_mcr)  rdata = {run, 15'b0};
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state       <= IDLE;
      o_Data      <= 16'h0000;
      o_Ready_Bit <= 1'b0;
      kb_full     <= 1'b0;
      kb_ie       <= 1'b0;
      kb_byte     <= 8'h00;
      dsp_empty   <= 1'b1;
      dsp_ie      <= 1'b0;
      o_DSP_Valid <= 1'b0;
      o_DSP_Data  <= 8'h00;
      run         <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= DONE;
          o_Ready_Bit <= 1'b1;
          if (!i_RW) o_Data <= rdata;
        end
        DONE: if (!i_MIO_EN) begin
          state       <= IDLE;
          o_Ready_Bit <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Clear-on-read comes first so a byte arriving on the same edge is kept.
      if (rd && sel_kbdr) kb_full <= 1'b0;
      if (kb_hs) begin
        kb_full <= 1'b1;
        kb_byte <= i_KB_Data;
      end
      if (wr && sel_kbsr) kb_ie <= i_MDR[14];

      if (dsp_hs) begin
        o_DSP_Valid <= 1'b0;
        dsp_empty   <= 1'b1;
      end
      if (wr && sel_ddr && dsp_empty) begin
        o_DSP_Data  <= i_MDR[7:0];
        o_DSP_Valid <= 1'b1;
        dsp_empty   <= 1'b0;
      end
      if (wr && sel_dsr) dsp_ie <= i_MDR[14];

      if (wr && sel_mcr) run <= i_MDR[15];
    end
  end

endmodule

// File: tb/tb_io_control.sv
// Scoreboard bench for io_control: read expectations are queued at issue and
// popped when the access reports ready.
module tb_io_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mar, mdr;
  logic        mio, rw;
  logic        io_sel, ready;
  logic [15:0] data;
  logic [7:0]  kb_data, dsp_data;
  logic        kb_valid, kb_ready, dsp_valid, dsp_ready, kb_int, run;

  int nvec = 0;
  int nerr = 0;
  logic [15:0] exp_q[$];

  io_control dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_MAR(mar), .i_MDR(mdr), .i_MIO_EN(mio), .i_RW(rw),
    .o_IO_Sel(io_sel), .o_Data(data), .o_Ready_Bit(ready),
    .i_KB_Data(kb_data), .i_KB_Valid(kb_valid), .o_KB_Ready(kb_ready),
    .o_DSP_Data(dsp_data), .o_DSP_Valid(dsp_valid), .i_DSP_Ready(dsp_ready),
    .o_KB_Int(kb_int), .o_Run(run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    nvec++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // One bus access; optional keyboard byte offered while the access sits in DONE.
  task automatic access(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                        input int hold, input logic feed, input logic [7:0] fb);
    int n;
    logic [15:0] e;
    @(negedge clk);
    mar = addr; mdr = wdata; rw = wr; mio = 1'b1;
    n = 0;
    @(posedge clk); #1;
    while (!ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_latency", 16'(n), 16'd0);
    if (!wr) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk($sformatf("rdata@%h", addr), data, e);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (feed && i == 1) begin kb_data = fb; kb_valid = 1'b1; end
      else kb_valid = 1'b0;
    end
    @(negedge clk);
    kb_valid = 1'b0; mio = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", 16'(ready), 16'd0);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] expv);
    exp_q.push_back(expv);
    access(addr, 1'b0, 16'h0, 0, 1'b0, 8'h0);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] wdata);
    access(addr, 1'b1, wdata, 0, 1'b0, 8'h0);
  endtask

  task automatic kb_feed(input logic [7:0] b);
    @(negedge clk);
    kb_data = b; kb_valid = 1'b1;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  task automatic no_sel(input logic [15:0] addr);
    @(negedge clk);
    mar = addr; rw = 1'b0; mio = 1'b1;
    #1 chk($sformatf("io_sel@%h", addr), 16'(io_sel), 16'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk($sformatf("no_ready@%h", addr), 16'(ready), 16'd0);
    end
    @(negedge clk);
    mio = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mar = 16'h0; mdr = 16'h0; mio = 1'b0; rw = 1'b0;
    kb_data = 8'h0; kb_valid = 1'b0; dsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // reset state
    chk("rst_ready", 16'(ready), 16'd0);
    chk("rst_data", data, 16'h0000);
    chk("rst_kb_ready", 16'(kb_ready), 16'd1);
    chk("rst_dsp_valid", 16'(dsp_valid), 16'd0);
    chk("rst_run", 16'(run), 16'd1);
    rd(16'hFE00, 16'h0000);
    rd(16'hFE04, 16'h8000);
    rd(16'hFFFE, 16'h8000);

    // keyboard byte in
    kb_feed(8'h41);
    chk("kb_ready_full", 16'(kb_ready), 16'd0);
    rd(16'hFE00, 16'h8000);
    rd(16'hFE02, 16'h0041);
    rd(16'hFE00, 16'h0000);
    chk("kb_ready_empty", 16'(kb_ready), 16'd1);

    // display byte out, second write dropped while busy
    @(negedge clk); mar = 16'hFE06; #1 chk("io_sel_ddr", 16'(io_sel), 16'd1);
    wr(16'hFE06, 16'h0048);
    chk("dsp_valid_set", 16'(dsp_valid), 16'd1);
    chk("dsp_data", 16'(dsp_data), 16'h0048);
    rd(16'hFE04, 16'h0000);
    wr(16'hFE06, 16'h0049);
    chk("dsp_data_hold", 16'(dsp_data), 16'h0048);
    @(negedge clk); dsp_ready = 1'b1;
    @(negedge clk); dsp_ready = 1'b0;
    chk("dsp_valid_clr", 16'(dsp_valid), 16'd0);
    rd(16'hFE04, 16'h8000);

    // keyboard interrupt
    wr(16'hFE00, 16'h4000);
    chk("kb_int_idle", 16'(kb_int), 16'd0);
    kb_feed(8'h0D);
    chk("kb_int_set", 16'(kb_int), 16'd1);
    rd(16'hFE00, 16'hC000);
    rd(16'hFE02, 16'h000D);
    chk("kb_int_clr", 16'(kb_int), 16'd0);

    // halt and decode misses
    wr(16'hFFFE, 16'h0000);
    chk("run_halt", 16'(run), 16'd0);
    rd(16'hFFFE, 16'h0000);
    no_sel(16'hFE08);
    no_sel(16'h3000);

    // long KBDR read: a byte arriving mid-DONE must survive (single clear)
    kb_feed(8'h55);
    exp_q.push_back(16'h0055);
    access(16'hFE02, 1'b0, 16'h0, 5, 1'b1, 8'h66);
    rd(16'hFE00, 16'hC000);
    rd(16'hFE02, 16'h0066);
    chk("kb_ready_after", 16'(kb_ready), 16'd1);

    // reset while in DONE with a display byte pending
    wr(16'hFE06, 16'h005A);
    chk("pre_rst_valid", 16'(dsp_valid), 16'd1);
    kb_feed(8'h77);
    @(negedge clk); mar = 16'hFE02; rw = 1'b0; mio = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_ready", 16'(ready), 16'd1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready", 16'(ready), 16'd0);
    chk("mid_rst_data", data, 16'h0000);
    chk("mid_rst_valid", 16'(dsp_valid), 16'd0);
    chk("mid_rst_dspdata", 16'(dsp_data), 16'h0000);
    chk("mid_rst_run", 16'(run), 16'd1);
    chk("mid_rst_kb_ready", 16'(kb_ready), 16'd1);
    @(negedge clk); rst_n = 1'b1; mio = 1'b0;
    rd(16'hFE04, 16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
